peripheral_timer_array: RTL

Parametrised multi-channel timer peripheral: `CHANNELS` independent counters of `WIDTH` bits, each with reload, one-shot and free-run modes, an 8-bit prescaler, and sticky write-1-to-clear status. It sits behind the peripheral register bus as a core, with a word-strobed register file of four registers per channel. It drives one registered interrupt line to the system interrupt controller.

---
 rtl/peripheral_timer_pkg.sv | 33 +++
 rtl/peripheral_timer_array_if.sv | 16 +
 rtl/timer_channel.sv | 145 ++++++++++++++
 rtl/peripheral_timer_array.sv | 43 ++++
 4 files changed

// File: rtl/peripheral_timer_pkg.sv
// Shared definitions for the multi-channel timer peripheral.
// Holds the counting-mode enum, per-channel register offsets and the bit
// positions of the CONFIG and STATUS registers.
package peripheral_timer_pkg;

    typedef enum logic [1:0] {
        MODE_RELOAD     = 2'b00,
        MODE_ONESHOT    = 2'b01,
        MODE_FREE       = 2'b10,
        MODE_RELOAD_ALT = 2'b11   // behaves exactly like MODE_RELOAD
    } timer_mode_t;

    localparam int REGS_PER_CH = 4;

    // Word offsets inside one channel's register block
    localparam int COUNT_OFS  = 0;
    localparam int RELOAD_OFS = 1;
    localparam int CONFIG_OFS = 2;
    localparam int STATUS_OFS = 3;

    // CONFIG fields
    localparam int CFG_EN_BIT    = 0;
    localparam int CFG_DIR_BIT   = 1;
    localparam int CFG_IRE_BIT   = 2;
    localparam int CFG_MODE_LSB  = 3;
    localparam int CFG_PRESC_LSB = 8;

    // STATUS fields
    localparam int ST_TC_BIT  = 0;
    localparam int ST_OVR_BIT = 1;
    localparam int ST_RUN_BIT = 2;

endpackage

// File: rtl/peripheral_timer_array_if.sv
// Register-bus bundle between a bus master and the timer array.
//   write_en : one-hot word write strobe, index = 4*channel + offset
//   data_in  : write data
//   data_out : live read value of every register word
//   irq_out  : registered interrupt request
interface peripheral_timer_array_if #(
    parameter int REGS = 16
);
    logic [REGS-1:0]       write_en;
    logic [31:0]           data_in;
    logic [REGS-1:0][31:0] data_out;
    logic                  irq_out;

    modport master (output write_en, data_in, input  data_out, irq_out);
    modport slave  (input  write_en, data_in, output data_out, irq_out);
endinterface

// File: rtl/timer_channel.sv
// One timer channel: COUNT/RELOAD/CONFIG/STATUS registers, 8-bit prescaler,
// up/down step with RELOAD / ONESHOT / FREE terminal behaviour and
// write-1-to-clear status flags.
//   clk, reset : clock, synchronous active-low reset
//   we_i       : per-register write strobes (COUNT, RELOAD, CONFIG, STATUS)
//   wdata_i    : write data
//   rdata_o    : zero-extended read value of each register
//   irq_req_o  : tc & ire, unregistered
module timer_channel
    import peripheral_timer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [REGS_PER_CH-1:0]       we_i,
    input  logic [31:0]                  wdata_i,
    output logic [REGS_PER_CH-1:0][31:0] rdata_o,
    output logic                         irq_req_o
);

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             en_q, en_d;
    logic             dir_q, dir_d;
    logic             ire_q, ire_d;
    logic [1:0]       mode_q, mode_d;
    logic [7:0]       presc_q, presc_d;
    logic [7:0]       pcnt_q, pcnt_d;
    logic             tc_q, tc_d;
    logic             ovr_q, ovr_d;

    timer_mode_t      mode_e;
    logic             is_free, is_oneshot;
    logic [WIDTH-1:0] term_val, count_step, load_val;
    logic             at_term, tick, fire, clr_tc;

    assign mode_e     = timer_mode_t'(mode_q);
    assign is_free    = (mode_e == MODE_FREE);
    assign is_oneshot = (mode_e == MODE_ONESHOT);

    // FREE uses the natural wrap point as terminal; the other modes use
    // 0 (down) or RELOAD (up).
    assign term_val   = is_free ? (dir_q ? ALL_ONES : '0)
                                : (dir_q ? reload_q : '0);
    assign at_term    = (count_q == term_val);
    assign count_step = dir_q ? count_q + ONE : count_q - ONE;
    assign load_val   = (is_free || !at_term) ? count_step
                                              : (dir_q ? '0 : reload_q);

    assign tick   = en_q && (pcnt_q == presc_q);
    // A COUNT write in the same cycle overrides the step, so no event.
    assign fire   = tick && at_term && !we_i[COUNT_OFS];
    assign clr_tc = we_i[STATUS_OFS] && wdata_i[ST_TC_BIT];

    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        en_d     = en_q;
        dir_d    = dir_q;
        ire_d    = ire_q;
        mode_d   = mode_q;
        presc_d  = presc_q;
        pcnt_d   = pcnt_q;
        tc_d     = tc_q;
        ovr_d    = ovr_q;

        if (en_q) pcnt_d = tick ? 8'd0 : pcnt_q + 8'd1;
        if (tick) count_d = load_val;
        if (fire && is_oneshot) en_d = 1'b0;

        if (we_i[COUNT_OFS])  count_d  = wdata_i[WIDTH-1:0];
        if (we_i[RELOAD_OFS]) reload_d = wdata_i[WIDTH-1:0];

        // CONFIG write beats a one-shot auto-disable and restarts the prescaler
        if (we_i[CONFIG_OFS]) begin
            en_d    = wdata_i[CFG_EN_BIT];
            dir_d   = wdata_i[CFG_DIR_BIT];
            ire_d   = wdata_i[CFG_IRE_BIT];
            mode_d  = wdata_i[CFG_MODE_LSB +: 2];
            presc_d = wdata_i[CFG_PRESC_LSB +: 8];
            pcnt_d  = 8'd0;
        end

        if (clr_tc) tc_d = 1'b0;
        if (we_i[STATUS_OFS] && wdata_i[ST_OVR_BIT]) ovr_d = 1'b0;

        // Set beats clear; a same-cycle clear of tc means this event is
        // not an overrun.
        if (fire) begin
            tc_d = 1'b1;
            if (tc_q && !clr_tc) ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q  <= '0;
            reload_q <= '0;
            en_q     <= 1'b0;
            dir_q    <= 1'b0;
            ire_q    <= 1'b0;
            mode_q   <= 2'b00;
            presc_q  <= 8'd0;
            pcnt_q   <= 8'd0;
            tc_q     <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            en_q     <= en_d;
            dir_q    <= dir_d;
            ire_q    <= ire_d;
            mode_q   <= mode_d;
            presc_q  <= presc_d;
            pcnt_q   <= pcnt_d;
            tc_q     <= tc_d;
            ovr_q    <= ovr_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        rdata_o[COUNT_OFS][WIDTH-1:0]             = count_q;
        rdata_o[RELOAD_OFS][WIDTH-1:0]            = reload_q;
        rdata_o[CONFIG_OFS][CFG_EN_BIT]           = en_q;
        rdata_o[CONFIG_OFS][CFG_DIR_BIT]          = dir_q;
        rdata_o[CONFIG_OFS][CFG_IRE_BIT]          = ire_q;
        rdata_o[CONFIG_OFS][CFG_MODE_LSB +: 2]    = mode_q;
        rdata_o[CONFIG_OFS][CFG_PRESC_LSB +: 8]   = presc_q;
        rdata_o[STATUS_OFS][ST_TC_BIT]            = tc_q;
        rdata_o[STATUS_OFS][ST_OVR_BIT]           = ovr_q;
        rdata_o[STATUS_OFS][ST_RUN_BIT]           = en_q;
    end

    assign irq_req_o = tc_q & ire_q;

    // Upper write-data bits are deliberately dropped for narrow channels.
    logic unused_wdata;
    assign unused_wdata = ^wdata_i;

endmodule

// File: rtl/peripheral_timer_array.sv
// Multi-channel timer peripheral. Instantiates CHANNELS independent
// timer_channel blocks behind a word-strobed register bus and registers
// the OR of their interrupt requests.
//   clk   : clock
//   reset : synchronous active-low reset
//   bus   : register bus (write_en, data_in, data_out, irq_out)
module peripheral_timer_array
    import peripheral_timer_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    peripheral_timer_array_if.slave   bus
);

    logic [CHANNELS-1:0] irq_req;
    logic                irq_q, irq_d;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        timer_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .we_i      (bus.write_en[g*REGS_PER_CH +: REGS_PER_CH]),
            .wdata_i   (bus.data_in),
            .rdata_o   (bus.data_out[g*REGS_PER_CH +: REGS_PER_CH]),
            .irq_req_o (irq_req[g])
        );
    end

    assign irq_d = |irq_req;

    always_ff @(posedge clk) begin
        if (!reset) irq_q <= 1'b0;
        else        irq_q <= irq_d;
    end

    assign bus.irq_out = irq_q;

endmodule
